w_feed: RTL and testbench
=========================

# w_feed

Write-side feeder for the dual-port RAM FIFO: accepts a valid/ready input stream in the write clock domain and drives the write enable and write data of the FIFO write control and RAM. A 2-entry skid buffer isolates the upstream handshake from the registered full flag, so no word is lost or duplicated when the FIFO fills or drains. The block also keeps a running count of words committed to the FIFO.

## Interface
- DATA_W, 8, width of one data word
- w_clk  input  1  write clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream word present
- in_data  input  DATA_W  upstream word
- in_ready  output  1  block can accept a word this cycle
- w_full  input  1  registered full flag from the FIFO write control
- w_en  output  1  write strobe to the FIFO write control and RAM
- w_data  output  DATA_W (DATA_W+1 with parity build)  word written when w_en=1
- wr_cnt  output  16  total words written since reset

## Operation
- Accept: in_valid & in_ready. Commit: w_en.
- Storage: head register H, tail register T; state machine EMPTY, ONE (H valid), TWO (H and T valid).
- in_ready = rst_n & (state != TWO). It depends only on state, never on in_valid or w_full.
- w_en = (state != EMPTY) & ~w_full. w_data = H.
- Transitions (A = accept, C = commit):
  - EMPTY: A -> ONE, H <= in_data. Otherwise EMPTY. C is impossible in this state.
  - ONE, A & C -> ONE, H <= in_data.
  - ONE, A only -> TWO, T <= in_data.
  - ONE, C only -> EMPTY.
  - ONE, neither -> ONE.
  - TWO, C -> ONE, H <= T. A is impossible in this state.
  - TWO, no C -> TWO.
- Ordering: words reach w_data in exact acceptance order, with no drops and no duplicates.
- wr_cnt increments by 1 on every cycle with w_en=1. It is 16-bit unsigned and wraps 0xFFFF -> 0x0000.
- w_full=1 holds w_en at 0. H and T are held, and the upstream stalls once the state reaches TWO.

## Timing
- Reset (rst_n=0 sampled at the edge):
  - state <= EMPTY; H, T <= 0; wr_cnt <= 0.
  - in_ready is 0 while rst_n=0.
  - w_en=0 and w_data=0 after the first reset edge.
- Reset mid-operation: buffered words are discarded. There is no commit on the reset edge and the next cycle, and the counter clears.
- Latency: a word accepted at edge N appears on w_data with w_en=1 in cycle N+1 if w_full=0 (1-cycle latency).
- Throughput: one word per cycle sustained while w_full=0.
- w_full rises: at most 2 words are held. The upstream sees in_ready=0 from the cycle after the state reaches TWO.
- w_full falls: the commit from H starts in the same cycle. in_ready returns to 1 the cycle after the first commit from TWO.
- Simultaneous accept and commit in ONE: the new word replaces H with no bubble.

## Configuration
- W_FEED_PARITY_EN defined:
  - w_data is DATA_W+1 bits.
  - Bit DATA_W = even parity (XOR) of the data bits, computed at accept time and stored with the word in H/T.
  - The RAM width must match.
- Undefined: w_data is DATA_W bits and no parity logic is built.
- Handshake, timing and wr_cnt are identical in both builds.

## Test plan
- Reset then stream 0x01..0x10 with w_full=0 and in_valid held high:
  - w_en high from cycle 2 to cycle 17.
  - w_data = 0x01..0x10 in order.
  - wr_cnt = 16.
- Stream 0xA0..0xA5, force w_full=1 for 5 cycles after 0xA1 commits:
  - in_ready drops after 0xA2 and 0xA3 are buffered.
  - On release, w_data = 0xA2, 0xA3, 0xA4, 0xA5 with no gaps and no duplicates.
- Toggle in_valid and w_full with random 50% patterns over 1000 words against a reference queue:
  - Exact match of order.
  - wr_cnt = 1000.
- Preload wr_cnt near wrap by writing 65535 words, then write 2 more: wr_cnt reads 0xFFFF then 0x0000 then 0x0001.
- Assert rst_n=0 for 1 cycle while in state TWO holding 0x55, 0x66: buffered 0x55 and 0x66 are never written, and wr_cnt = 0.
- W_FEED_PARITY_EN build, write 0x07 then 0x03: w_data = 0x107 then 0x003.

Source files
------------

// File: rtl/w_feed.sv
// w_feed: skid-buffered write feeder for the RAM FIFO; define W_FEED_PARITY_EN to append even parity to each word
module w_feed #(
  parameter int DATA_W = 8,
`ifdef W_FEED_PARITY_EN
  localparam int WW = DATA_W + 1
`else
  localparam int WW = DATA_W
`endif
) (
  input  logic              w_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              w_full,
  output logic              w_en,
  output logic [WW-1:0]     w_data,
  output logic [15:0]       wr_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [WW-1:0] h, t, h_nx, t_nx, in_w;
  logic acc;
`ifdef W_FEED_PARITY_EN
  assign in_w = {^in_data, in_data};
`else
  assign in_w = in_data;
`endif
  assign in_ready = rst_n & (state != TWO);
  assign w_en = rst_n & (state != EMPTY) & ~w_full;
  assign w_data = h;
  assign acc = in_valid & in_ready;
  // next state of the two-entry skid buffer; H always holds the oldest word
  always_comb begin
    state_nx = state;
    h_nx = h;
    t_nx = t;
    case (state)
      EMPTY: begin
        state_nx = acc ? ONE : EMPTY;
        h_nx = acc ? in_w : h;
      end
      ONE: begin
        state_nx = (acc & ~w_en) ? TWO : (~acc & w_en) ? EMPTY : ONE;
        h_nx = (acc & w_en) ? in_w : h;
        t_nx = (acc & ~w_en) ? in_w : t;
      end
      TWO: begin
        state_nx = w_en ? ONE : TWO;
        h_nx = w_en ? t : h;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // buffer registers and committed-word counter
  always_ff @(posedge w_clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      h <= '0;
      t <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_nx;
      h <= h_nx;
      t <= t_nx;
      wr_cnt <= wr_cnt + 16'(w_en);
    end
  end
endmodule

// File: tb/tb_w_feed.sv
// tb_w_feed: directed and scoreboarded checks of w_feed ordering, stalls, reset and counter wrap
module tb_w_feed;
`ifdef W_FEED_PARITY_EN
  localparam int WW = 9;
`else
  localparam int WW = 8;
`endif
  logic w_clk, rst_n, in_valid, in_ready, w_full, w_en;
  logic [7:0] in_data;
  logic [WW-1:0] w_data;
  logic [15:0] wr_cnt;
  logic [WW-1:0] q[$];
  logic [WW-1:0] committed[$];
  logic acc;
  int errors, checks, exp_cnt;

  w_feed dut (
    .w_clk(w_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_full(w_full), .w_en(w_en), .w_data(w_data), .wr_cnt(wr_cnt)
  );

  initial w_clk = 0;
  always #5 w_clk = ~w_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WW-1:0] word(input logic [7:0] d);
`ifdef W_FEED_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic f);
    @(negedge w_clk);
    in_valid = v;
    in_data = d;
    w_full = f;
    #1;
    acc = in_valid & in_ready;
    if (w_en) begin
      if (q.size() == 0) check("spurious_wen", w_en, 0);
      else check("order", w_data, q.pop_front());
      committed.push_back(w_data);
      exp_cnt++;
    end
    if (acc) q.push_back(word(d));
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("rst_ready", in_ready, 0);
    check("rst_wen", w_en, 0);
    check("rst_wdata", w_data, 0);
    check("rst_cnt", wr_cnt, 0);
    q.delete();
    committed.delete();
    exp_cnt = 0;
    rst_n = 1;
  endtask

  initial begin
    int idx, n;
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    rst_n = 0;
    in_valid = 0;
    in_data = 0;
    w_full = 0;
    do_reset();
    // stream 0x01..0x10
    for (int c = 1; c <= 18; c++) begin
      cycle(c <= 16, 8'(c), 0);
      check("t1_wen", w_en, (c >= 2 && c <= 17));
    end
    check("t1_cnt", wr_cnt, 16);
    // stall with w_full after 0xA1 commits
    committed.delete();
    idx = 0;
    for (int c = 1; c <= 13; c++) begin
      cycle(idx < 6, 8'(8'hA0 + idx), (c >= 4 && c <= 8));
      if (acc) idx++;
      if (c == 4) check("t2_rdy_open", in_ready, 1);
      if (c >= 5 && c <= 9) check("t2_rdy_stall", in_ready, 0);
      if (c >= 4 && c <= 8) check("t2_wen_held", w_en, 0);
      if (c >= 9 && c <= 12) check("t2_wen_drain", w_en, 1);
      if (c == 13) check("t2_wen_idle", w_en, 0);
    end
    check("t2_count", committed.size(), 6);
    for (int i = 0; i < 6 && i < committed.size(); i++)
      check("t2_word", committed[i], 8'hA0 + i);
    // random valid / full over 1000 words
    do_reset();
    n = 0;
    for (int k = 0; k < 20000 && (n < 1000 || q.size() != 0); k++) begin
      cycle((n < 1000) && ($urandom_range(0, 1) == 1), 8'(n * 7 + 3),
            (n < 1000) && ($urandom_range(0, 1) == 1));
      if (acc) n++;
    end
    check("rand_drained", q.size(), 0);
    check("rand_accepted", n, 1000);
    cycle(0, 0, 0);
    check("rand_cnt", wr_cnt, 1000);
    // reset while holding 0x55, 0x66
    do_reset();
    cycle(1, 8'h55, 1);
    cycle(1, 8'h66, 1);
    cycle(0, 0, 1);
    check("mid_two_rdy", in_ready, 0);
    check("mid_cnt_before", wr_cnt, 0);
    cycle(1, 8'h77, 1);
    cycle(1, 8'h77, 1);
    check("mid_cnt_pre", wr_cnt, 0);
    rst_n = 0;
    cycle(0, 0, 0);
    check("mid_rst_wen", w_en, 0);
    rst_n = 1;
    q.delete();
    exp_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(0, 0, 0);
      check("mid_post_wen", w_en, 0);
    end
    check("mid_post_cnt", wr_cnt, 0);
    // counter wrap
    do_reset();
    for (int k = 0; k < 70000 && exp_cnt < 65535; k++) cycle(1, 8'(k), 0);
    cycle(1, 8'h11, 0);
    check("wrap_ffff", wr_cnt, 16'hFFFF);
    cycle(1, 8'h22, 0);
    check("wrap_0000", wr_cnt, 16'h0000);
    cycle(0, 0, 0);
    check("wrap_0001", wr_cnt, 16'h0001);
    for (int c = 0; c < 4; c++) cycle(0, 0, 0);
    check("wrap_drained", q.size(), 0);
`ifdef W_FEED_PARITY_EN
    do_reset();
    cycle(1, 8'h07, 0);
    cycle(1, 8'h03, 0);
    check("par_07", w_data, 9'h107);
    cycle(0, 0, 0);
    check("par_03", w_data, 9'h003);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
